// File: rtl/temp_f_to_c_pkg.sv
// Shared constants, FSM state type and width helper for the Fahrenheit-to-Celsius converter.
package temp_conv_pkg;

  localparam int F_OFFSET    = 32;
  localparam int C_SCALE_NUM = 5;
  localparam int C_SCALE_DEN = 9;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  // Three extra bits cover the x5 scaling of |f - 32| for any input width.
  function automatic int div_w(input int in_w);
    return in_w + 3;
  endfunction

endpackage

// File: rtl/temp_f_to_c_if.sv
// Valid/ready sample-in, result-out bundle for temp_f_to_c.
interface temp_f_to_c_if #(
  parameter int IN_W = 8
);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] f;
  logic            out_valid;
  logic            out_ready;
  logic [IN_W-1:0] c;
  logic [3:0]      rem;

  modport master (
    output in_valid, f, out_ready,
    input  in_ready, out_valid, c, rem
  );

  modport slave (
    input  in_valid, f, out_ready,
    output in_ready, out_valid, c, rem
  );

endinterface

// File: rtl/temp_f_to_c_seq_divider.sv
// Restoring bit-serial unsigned divider by a constant, one quotient bit per clock, MSB first.
module seq_divider
  import temp_conv_pkg::*;
#(
  parameter int W     = 11,
  parameter int QW    = 8,
  parameter int DEN   = C_SCALE_DEN,
  parameter int REM_W = $clog2(DEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     dividend,
  output logic             busy,
  output logic             done,
  output logic [QW-1:0]    quotient,
  output logic [REM_W-1:0] remainder
);

  localparam int CNT_W = $clog2(W);

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     dvd;
  logic [REM_W-1:0] part;
  logic [QW-1:0]    quo;
  logic [REM_W:0]   trial;
  logic             step_bit;
  logic [REM_W-1:0] step_rem;

  always_comb begin
    trial    = {part, dvd[W-1]};
    step_bit = (trial >= (REM_W+1)'(DEN));
    step_rem = trial[REM_W-1:0];
    if (step_bit) begin
      step_rem = REM_W'(trial - (REM_W+1)'(DEN));
    end
  end

  // The quotient is known to fit in QW bits, so high bits shifting out of quo are always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      dvd  <= '0;
      part <= '0;
      quo  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(W - 1);
      dvd  <= dividend;
      part <= '0;
      quo  <= '0;
    end else if (busy) begin
      part <= step_rem;
      quo  <= {quo[QW-2:0], step_bit};
      dvd  <= {dvd[W-2:0], 1'b0};
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = quo;
  assign remainder = part;

endmodule

// File: rtl/temp_f_to_c.sv
// Sequential Fahrenheit-to-Celsius converter: c = trunc((f - 32) * 5 / 9) with valid/ready handshakes.
module temp_f_to_c
  import temp_conv_pkg::*;
#(
  parameter int IN_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  temp_f_to_c_if.slave  bus
);

  localparam int DIV_W = div_w(IN_W);

  state_t          state;
  state_t          state_nxt;
  logic            sign_q;
  logic            accept;
  logic            below;
  logic [IN_W-1:0] diff;
  logic [DIV_W-1:0] diff_ext;
  logic [DIV_W-1:0] mag;
  logic            div_busy;
  logic            div_done;
  logic [IN_W-1:0] quo;
  logic [3:0]      div_rem;

  assign accept = (state == IDLE) && bus.in_valid;

  // Magnitude front end; the x5 scale is a shift-and-add so no multiplier is needed.
  always_comb begin
    below    = (bus.f < IN_W'(F_OFFSET));
    diff     = below ? (IN_W'(F_OFFSET) - bus.f) : (bus.f - IN_W'(F_OFFSET));
    diff_ext = DIV_W'(diff);
    mag      = (diff_ext << 2) + diff_ext;
  end

  seq_divider #(
    .W   (DIV_W),
    .QW  (IN_W),
    .DEN (C_SCALE_DEN)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .dividend  (mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sign_q <= below;
      end
    end
  end

  // DIV falls back to IDLE if the divider is somehow idle without signalling completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = DIV;
      DIV: begin
        if (div_done) begin
          state_nxt = DONE;
        end else if (!div_busy) begin
          state_nxt = IDLE;
        end
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; negating a zero quotient naturally yields zero.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.c         = (state == DONE) ? (sign_q ? -quo : quo) : '0;
  assign bus.rem       = (state == DONE) ? div_rem : '0;

endmodule

// File: tb/tb_temp_f_to_c.sv
// Scoreboard bench for temp_f_to_c: directed corners, backpressure, mid-divide reset and a stalled sweep.
module tb_temp_f_to_c;

  typedef struct {
    logic [7:0] c;
    logic [3:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic hold_ready = 1'b1;
  logic random_stall = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  int   produced = 0;
  logic held = 1'b0;
  logic [7:0] last_c = '0;
  logic [3:0] last_rem = '0;
  exp_t sb[$];

  temp_f_to_c_if #(.IN_W(8)) bus ();

  temp_f_to_c #(.IN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t model(input int fv);
    exp_t e;
    int d, m, q;
    d = fv - 32;
    m = ((d < 0) ? -d : d) * 5;
    q = m / 9;
    e.c   = (d < 0) ? 8'(-q) : 8'(q);
    e.rem = 4'(m % 9);
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    bus.out_ready = random_stall ? ($urandom_range(0, 3) != 0) : hold_ready;
  end

  // Push on accepted input, pop on output handshake, and watch output stability under stall.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(int'(bus.f)));
        accepted++;
      end
      if (bus.out_valid) begin
        if (held) begin
          checkOutput("hold_c", {24'b0, bus.c}, {24'b0, last_c});
          checkOutput("hold_rem", {28'b0, bus.rem}, {28'b0, last_rem});
        end
        if (bus.out_ready) begin
          produced++;
          if (sb.size() == 0) begin
            checkOutput("unexpected_out", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("c", {24'b0, bus.c}, {24'b0, e.c});
            checkOutput("rem", {28'b0, bus.rem}, {28'b0, e.rem});
          end
        end
      end
      held     = bus.out_valid && !bus.out_ready;
      last_c   = bus.c;
      last_rem = bus.rem;
    end else begin
      held = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] fv);
    int n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.f        = fv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(bus.in_ready && sb.size() == 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(bus.in_ready && sb.size() == 0)) begin
      checkOutput("idle_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int a0, p0;
    int n;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.f        = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_c", {24'b0, bus.c}, 32'd0);
    checkOutput("rst_rem", {28'b0, bus.rem}, 32'd0);
    rst_n = 1'b1;

    // Latency and in_ready during the divide.
    applyStimulus(8'd212);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (bus.out_valid) break;
      checkOutput("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
      lat++;
    end
    checkOutput("latency", lat, 32'd11);
    waitIdle();

    applyStimulus(8'd32);  waitIdle();
    applyStimulus(8'd31);  waitIdle();
    applyStimulus(8'd0);   waitIdle();
    applyStimulus(8'd255); waitIdle();
    applyStimulus(8'd98);  waitIdle();

    // Backpressure with an ignored sample offered during the stall.
    hold_ready = 1'b0;
    applyStimulus(8'd212);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_reach_valid", {31'b0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.f        = 8'd50;
      end
      if (i == 8) bus.in_valid = 1'b0;
      checkOutput("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("bp_c", {24'b0, bus.c}, 32'd100);
      checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    hold_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("bp_in_ready_back", {31'b0, bus.in_ready}, 32'd1);
    applyStimulus(8'd50);
    waitIdle();

    // Asynchronous reset in the middle of a divide.
    applyStimulus(8'd212);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid_rst_c", {24'b0, bus.c}, 32'd0);
    checkOutput("mid_rst_rem", {28'b0, bus.rem}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'd98);
    waitIdle();

    // Full input sweep with random output stalls.
    a0 = accepted;
    p0 = produced;
    random_stall = 1'b1;
    for (int fv = 0; fv < 256; fv++) begin
      applyStimulus(8'(fv));
    end
    random_stall = 1'b0;
    hold_ready   = 1'b1;
    waitIdle();
    checkOutput("sweep_accepted", accepted - a0, 32'd256);
    checkOutput("sweep_produced", produced - p0, 32'd256);
    checkOutput("sb_leftover", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temp_f_to_c.md
# temp_f_to_c

Sequential Fahrenheit-to-Celsius converter computing c = trunc((f − 32) × 5 / 9) with a restoring bit-serial divider. It is the inverse companion of the combinational Celsius-to-Fahrenheit converter and sits on the display/sensor path wherever Fahrenheit readings must be shown in Celsius. Input and output use valid/ready handshakes, so it can sit between a sensor sampler and a display driver with backpressure.

## Interface
- IN_W, 8: unsigned Fahrenheit input width; internal dividend width DIV_W = IN_W + 3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  f is valid.
- in_ready  out  1  block accepts a sample; high only in IDLE.
- f  in  IN_W  unsigned Fahrenheit value.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- c  out  IN_W  signed two's-complement Celsius, truncated toward zero.
- rem  out  4  magnitude remainder of the divide by 9, range 0..8.

## Operation
- States: IDLE → DIV → DONE → IDLE.
- IDLE: in_ready = 1. On in_valid && in_ready at a clock edge:
  - register sign = (f < 32);
  - register mag = |f − 32| × 5 as DIV_W-bit unsigned (× 5 computed as (x << 2) + x);
  - clear the quotient and partial remainder;
  - load bit counter = DIV_W − 1;
  - go to DIV.
- DIV: one restoring step per cycle, MSB first.
  - Shift the next dividend bit into the partial remainder; if partial ≥ 9, subtract 9 and set the quotient bit to 1.
  - When the counter reaches 0, go to DONE.
  - Exactly DIV_W steps (11 for IN_W = 8).
- DONE: out_valid = 1.
  - c = sign ? −quotient : quotient; −0 is output as 0.
  - rem = final partial remainder (always the magnitude remainder, never negated).
  - c and rem are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE.
- Range for IN_W = 8: f 0..255 maps to c −17..123, so no overflow. The width is sized so that |f − 32| × 5 < 2^DIV_W for all IN_W.
- in_valid while not in IDLE is ignored; the sample is not captured.
- Reset (asynchronous, any state, including mid-divide): state = IDLE, in_ready = 1, out_valid = 0, c = 0, rem = 0. The in-flight sample is discarded. The first accept is possible on the first edge after rst_n deasserts.

## Timing
- Accept at edge E0. DIV steps occur at edges E1..E11. out_valid is high in the cycle after E11, so latency is 11 cycles from accept to out_valid (IN_W = 8).
- Output handshake at edge Eh, followed by IDLE. in_ready is high in the cycle after Eh.
- No same-cycle drain-and-accept. Minimum initiation interval is 13 cycles with out_ready held high.
- All outputs are registered. No combinational path from in_valid or out_ready to any output other than through state.

## Structure
- Package temp_conv_pkg holds:
  - F_OFFSET = 32, C_SCALE_NUM = 5, C_SCALE_DEN = 9;
  - the state enum {IDLE, DIV, DONE};
  - a DIV_W helper function.
- Sub-module seq_divider is an unsigned restoring divider by a constant.
  - Ports: clk, rst_n, start, dividend, busy, done, quotient, remainder.
  - temp_f_to_c wraps it with the offset/scale front end, the sign handling and the handshake FSM.

## Test plan
- f = 212, out_ready = 1 → c = 100, rem = 0. out_valid rises exactly 11 cycles after the accept edge; in_ready is low during the divide.
- f = 32 → c = 0, rem = 0. f = 31 → c = 0 (not −0), rem = 5.
- f = 0 → c = −17 (8'hEF), rem = 7. f = 255 → c = 123, rem = 8. f = 98 → c = 36, rem = 6.
- Backpressure: f = 212 with out_ready = 0 for 20 cycles → out_valid and c = 100 stay stable throughout. A second in_valid with f = 50 during the stall is ignored. After out_ready = 1, in_ready returns the next cycle, and f = 50 is then accepted → c = 10.
- Reset mid-operation: accept f = 212, assert rst_n = 0 at cycle 5 of DIV → out_valid = 0, c = 0, in_ready = 1 immediately. After release, f = 98 → c = 36 with no residue from the aborted sample.
- Exhaustive sweep of f = 0..255 with random out_ready stalls → every c and rem matches the truncate-toward-zero reference model, and exactly one result is produced per accepted sample.
